// File: rtl/lifo_rr_arbiter.sv
// Round-robin arbiter sharing one registered-output LIFO between NUM_REQ clients.
// Define LIFO_ARB_STATS_EN to add saturating push/pop/reject counters.
module lifo_rr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          asyn_n_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_push,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          req_err,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          lifo_push,
    output logic                          lifo_pop,
    output logic [DATA_WIDTH-1:0]         lifo_data_in,
    input  logic [DATA_WIDTH-1:0]         lifo_data_out,
    input  logic                          lifo_full,
    input  logic                          lifo_empty
`ifdef LIFO_ARB_STATS_EN
    ,
    output logic [15:0]                   stat_push_cnt,
    output logic [15:0]                   stat_pop_cnt,
    output logic [15:0]                   stat_err_cnt
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        POP_WAIT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       ptr_next;
    logic [ID_W-1:0]       pop_id;
    logic [ID_W-1:0]       pop_id_next;
    logic [ID_W-1:0]       winner;
    logic                  found;
    logic [ID_W:0]         scan_sum;
    logic [ID_W-1:0]       scan_idx;
    logic [DATA_WIDTH-1:0] winner_data;
    logic                  capture;

    // Rotating priority search starting at rr_ptr, wrapping mod NUM_REQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
                scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    always_comb begin
        winner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                winner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Grants are suppressed while reset is asserted so no strobe leaks out.
    always_comb begin
        state_next   = state;
        ptr_next     = rr_ptr;
        pop_id_next  = pop_id;
        req_ready    = '0;
        req_err      = 1'b0;
        lifo_push    = 1'b0;
        lifo_pop     = 1'b0;
        lifo_data_in = '0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (asyn_n_rst && found) begin
                    req_ready[winner] = 1'b1;
                    ptr_next = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + ID_W'(1);
                    if (req_push[winner]) begin
                        if (lifo_full) begin
                            req_err = 1'b1;
                        end else begin
                            lifo_push    = 1'b1;
                            lifo_data_in = winner_data;
                        end
                    end else if (lifo_empty) begin
                        req_err = 1'b1;
                    end else begin
                        lifo_pop    = 1'b1;
                        pop_id_next = winner;
                        state_next  = POP_WAIT;
                    end
                end
            end
            POP_WAIT: begin
                capture    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Response stage: lifo_data_out is valid in POP_WAIT and registered here.
    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            pop_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= ptr_next;
            pop_id    <= pop_id_next;
            rsp_valid <= capture;
            if (capture) begin
                rsp_id   <= pop_id;
                rsp_data <= lifo_data_out;
            end
        end
    end

`ifdef LIFO_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            stat_push_cnt <= '0;
            stat_pop_cnt  <= '0;
            stat_err_cnt  <= '0;
        end else begin
            if (lifo_push) stat_push_cnt <= sat_inc(stat_push_cnt);
            if (lifo_pop)  stat_pop_cnt  <= sat_inc(stat_pop_cnt);
            if (req_err)   stat_err_cnt  <= sat_inc(stat_err_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_lifo_rr_arbiter.sv
// Bench for lifo_rr_arbiter: behavioural LIFO, cycle model of the arbiter rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lifo_rr_arbiter;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int ID_W  = 2;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           asyn_n_rst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_push = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           req_err;
    logic           rsp_valid;
    logic [ID_W-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           lifo_push;
    logic           lifo_pop;
    logic [W-1:0]   lifo_data_in;
    logic [W-1:0]   lifo_data_out;
    logic           lifo_full;
    logic           lifo_empty;
`ifdef LIFO_ARB_STATS_EN
    logic [15:0]    stat_push_cnt;
    logic [15:0]    stat_pop_cnt;
    logic [15:0]    stat_err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    lifo_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W)) dut (
        .clk(clk), .asyn_n_rst(asyn_n_rst),
        .req_valid(req_valid), .req_push(req_push), .req_data(req_data),
        .req_ready(req_ready), .req_err(req_err),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_data_in(lifo_data_in),
        .lifo_data_out(lifo_data_out), .lifo_full(lifo_full), .lifo_empty(lifo_empty)
`ifdef LIFO_ARB_STATS_EN
        , .stat_push_cnt(stat_push_cnt), .stat_pop_cnt(stat_pop_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural LIFO the arbiter drives; force bits fake full/empty.
    logic [W-1:0] env_q[$];
    int           env_n = 0;
    logic [W-1:0] env_dout = '0;
    logic         force_full = 1'b0;
    logic         force_empty = 1'b0;
    assign lifo_data_out = env_dout;
    assign lifo_full  = force_full  || (env_n >= DEPTH);
    assign lifo_empty = force_empty || (env_n == 0);

    always @(posedge clk) begin
        if (lifo_push && env_q.size() < DEPTH) env_q.push_back(lifo_data_in);
        else if (lifo_pop && env_q.size() > 0) env_dout <= env_q.pop_back();
        env_n <= env_q.size();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rr pointer, pending-pop bookkeeping and its own stack.
    int           m_ptr = 0;
    bit           m_wait = 0;
    int           m_wait_id = 0;
    logic [W-1:0] m_pend = '0;
    bit           m_rsp_valid = 0;
    int           m_rsp_id = 0;
    logic [W-1:0] m_rsp_data = '0;
    logic [W-1:0] m_q[$];
    int           m_push_n = 0;
    int           m_pop_n = 0;
    int           m_err_n = 0;

    always @(negedge clk) begin : cmp
        logic [N-1:0] e_ready;
        logic         e_err, e_push, e_pop;
        logic [W-1:0] e_din;
        int           w;
        if (!asyn_n_rst) begin
            m_ptr = 0; m_wait = 0; m_rsp_valid = 0; m_rsp_id = 0; m_rsp_data = '0;
            m_push_n = 0; m_pop_n = 0; m_err_n = 0;
        end
        e_ready = '0; e_err = 0; e_push = 0; e_pop = 0; e_din = '0; w = -1;
        if (asyn_n_rst && !m_wait) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (w < 0 && req_valid[i]) w = i;
            end
            if (w >= 0) begin
                e_ready[w] = 1'b1;
                if (req_push[w]) begin
                    if (lifo_full) e_err = 1;
                    else begin e_push = 1; e_din = req_data[w*W +: W]; end
                end else if (lifo_empty) e_err = 1;
                else e_pop = 1;
            end
        end
        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("req_err", 64'(req_err), 64'(e_err));
        check("lifo_push", 64'(lifo_push), 64'(e_push));
        check("lifo_pop", 64'(lifo_pop), 64'(e_pop));
        check("lifo_data_in", 64'(lifo_data_in), 64'(e_din));
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        check("rsp_id", 64'(rsp_id), 64'(m_rsp_id));
        check("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
`ifdef LIFO_ARB_STATS_EN
        check("stat_push_cnt", 64'(stat_push_cnt), 64'(m_push_n));
        check("stat_pop_cnt", 64'(stat_pop_cnt), 64'(m_pop_n));
        check("stat_err_cnt", 64'(stat_err_cnt), 64'(m_err_n));
`endif
        if (asyn_n_rst) begin
            if (m_wait) begin
                m_rsp_valid = 1; m_rsp_id = m_wait_id; m_rsp_data = m_pend; m_wait = 0;
            end else begin
                m_rsp_valid = 0;
                if (w >= 0) begin
                    m_ptr = (w + 1) % N;
                    if (e_push) begin m_q.push_back(e_din); if (m_push_n < 65535) m_push_n++; end
                    if (e_pop) begin
                        m_pend = m_q.pop_back(); m_wait = 1; m_wait_id = w;
                        if (m_pop_n < 65535) m_pop_n++;
                    end
                    if (e_err && m_err_n < 65535) m_err_n++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] g;
        logic [N-1:0] exp_g[5];
        logic [W-1:0] exp_d[5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

        // Reset with requests pending: nothing may be granted.
        req_valid = 4'hF; req_push = 4'hF;
        repeat (3) step();
        req_valid = '0;
        step();
        asyn_n_rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_strobes", 64'({lifo_push, lifo_pop, req_ready, rsp_valid}), 64'd0);
            step();
        end

        // All four push: grants rotate 0,1,2,3,0.
        req_valid = 4'hF; req_push = 4'hF; req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_grant", 64'(req_ready), 64'(exp_g[k]));
            check("rr_data", 64'(lifo_data_in), 64'(exp_d[k]));
            step();
        end
        req_valid = '0;

        // Push 5A by req1, pop by req2, response two cycles after grant.
        req_valid = 4'b0010; req_push = 4'b0010; req_data[15:8] = 8'h5A;
        @(negedge clk);
        check("t3_push_grant", 64'(req_ready), 64'h2);
        check("t3_push_data", 64'(lifo_data_in), 64'h5A);
        step();
        req_valid = 4'b0100; req_push = 4'b0000;
        @(negedge clk);
        check("t3_pop_grant", 64'({req_ready, lifo_pop}), 64'b0100_1);
        step();
        req_valid = 4'b0001; req_push = 4'b0001; req_data[7:0] = 8'h33;
        @(negedge clk);
        check("t3_wait_no_grant", 64'({req_ready, rsp_valid}), 64'd0);
        step();
        @(negedge clk);
        check("t3_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 2'd2, 8'h5A}));
        check("t3_regrant", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t3_rsp_pulse", 64'(rsp_valid), 64'd0);
        step();

        // Rejected pop on empty, rejected push on full.
        force_empty = 1'b1; req_valid = 4'b0001; req_push = 4'b0000;
        @(negedge clk);
        check("t4_pop_reject", 64'({req_ready, req_err, lifo_pop}), 64'b0001_1_0);
        step();
        req_valid = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t4_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        force_empty = 1'b0; force_full = 1'b1; req_valid = 4'b0001; req_push = 4'b0001;
        @(negedge clk);
        check("t4_push_reject", 64'({req_ready, req_err, lifo_push}), 64'b0001_1_0);
        step();
        req_valid = '0; force_full = 1'b0;

        // Reset during POP_WAIT drops the response and clears rr_ptr.
        req_valid = 4'b0100; req_push = 4'b0000;
        @(negedge clk);
        check("t5_pop_grant", 64'(lifo_pop), 64'd1);
        step();
        req_valid = '0; asyn_n_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        asyn_n_rst = 1'b1;
        @(negedge clk);
        check("t5_no_rsp_after", 64'(rsp_valid), 64'd0);
        step();
        req_valid = 4'b1001; req_push = 4'b1001;
        @(negedge clk);
        check("t5_ptr_zero", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;

        // Randomized traffic, requests held until granted, occasional drops.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g = req_ready;
            @(posedge clk);
            #1;
            asyn_n_rst = !(c >= 1500 && c < 1502);
            for (int i = 0; i < N; i++) begin
                if (g[i] || (req_valid[i] && $urandom_range(0, 15) == 0)) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_push[i] = 1'($urandom_range(0, 1));
                    req_data[i*W +: W] = 8'($urandom);
                end
            end
        end
        req_valid = '0;
        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "time limit");
    end

endmodule
